// File: rtl/mult_share_arb_if.sv
// Requester and multiplier-side signals of mult_share_arb.
// The arbiter connects through the slave modport; the environment uses master.
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_ab;
  logic              timeout_err;
  logic              idle;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic              mul_start;
  logic              mul_busy;
  logic [15:0]       mul_ab;

  modport slave (
    input  req_valid, req_a, req_b, mul_busy, mul_ab,
    output req_ready, rsp_valid, rsp_id, rsp_ab, timeout_err, idle,
           mul_a, mul_b, mul_start
  );

  modport master (
    output req_valid, req_a, req_b, mul_busy, mul_ab,
    input  req_ready, rsp_valid, rsp_id, rsp_ab, timeout_err, idle,
           mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one start/busy sequential multiplier among NREQ
// requesters, with a timeout guard that still answers the requester on a stall.
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  mult_share_arb_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  grant_id;
  logic [IDW:0]    cand;
  logic            grant_found;
  logic            take;
  logic            timeout_hit;
  logic [NREQ-1:0] ready;
  logic [CW-1:0]   cnt;
  logic [7:0]      mul_a;
  logic [7:0]      mul_b;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     rsp_ab;
  logic            timeout_err;

  // Winner is the first valid requester found searching upward from ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[IDW-1:0];
      end
    end
  end

  assign take        = (state == IDLE) && !bus.mul_busy && grant_found;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    ready = '0;
    if (take) ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = ARM;
      ARM:     if (bus.mul_busy) state_nxt = RUN;
               else if (timeout_hit) state_nxt = RESP;
      RUN:     if (!bus.mul_busy || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      id          <= '0;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_id      <= '0;
      rsp_ab      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (take) begin
            mul_a <= bus.req_a[{grant_id, 3'b000} +: 8];
            mul_b <= bus.req_b[{grant_id, 3'b000} +: 8];
            id    <= grant_id;
            ptr   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        LAUNCH: cnt <= '0;
        ARM: begin
          if (!bus.mul_busy) begin
            if (timeout_hit) begin
              timeout_err <= 1'b1;
              rsp_ab      <= '0;
              rsp_id      <= id;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RUN: begin
          // A finished product wins over a timeout landing on the same cycle.
          if (!bus.mul_busy) begin
            rsp_ab <= bus.mul_ab;
            rsp_id <= id;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            rsp_ab      <= '0;
            rsp_id      <= id;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.mul_start   = (state == LAUNCH);
  assign bus.rsp_valid   = (state == RESP);
  assign bus.idle        = (state == IDLE);
  assign bus.mul_a       = mul_a;
  assign bus.mul_b       = mul_b;
  assign bus.rsp_id      = rsp_id;
  assign bus.rsp_ab      = rsp_ab;
  assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a start/busy multiplier model whose
// busy length is set per operation (or stalled entirely for the timeout case).
module tb_mult_share_arb;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;

  typedef struct {
    int id;
    int a;
    int b;
    int k;
    int exp_ab;
  } vec_t;

  typedef struct {
    int         lat;
    logic [3:0] rdy;
    int         starts;
    int         rid;
    int         rab;
    int         rab_after;
    logic       rv_after;
    logic       busy_g;
    logic       early_rsp;
    int         extra_rdy;
    logic       terr;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  mult_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Multiplier model: busy for mdl_k cycles starting the cycle after start;
  // the product appears only once busy drops.
  logic               mdl_busy  = 1'b0;
  logic [15:0]        mdl_out   = 16'h5A5A;
  logic signed [15:0] mdl_prod  = '0;
  int                 mdl_cnt   = 0;
  int                 mdl_k     = 8;
  logic               mdl_stall = 1'b0;

  assign bus.mul_busy = mdl_busy;
  assign bus.mul_ab   = mdl_out;

  always @(posedge clk) begin
    if (bus.mul_start && !mdl_stall) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= mdl_k;
      mdl_prod <= $signed(bus.mul_a) * $signed(bus.mul_b);
      mdl_out  <= 16'h5A5A;
    end else if (mdl_busy) begin
      if (mdl_cnt <= 1) begin
        mdl_busy <= 1'b0;
        mdl_out  <= mdl_prod;
      end
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One requester asks alone; grant, start pulses and the response are recorded.
  task automatic applyStimulus(input int id, input int a, input int b, input int k, output res_t r);
    logic granted;
    r = '{lat: -1, rdy: '0, starts: 0, rid: -1, rab: -1, rab_after: -1,
          rv_after: 1'b1, busy_g: 1'b0, early_rsp: 1'b0, extra_rdy: 0, terr: 1'b0};
    mdl_k = k;
    @(negedge clk);
    bus.req_a[id*8 +: 8] = 8'(a);
    bus.req_b[id*8 +: 8] = 8'(b);
    bus.req_valid[id]    = 1'b1;
    #1;
    granted = 1'b0;
    for (int c = 0; c < 80 && !granted; c++) begin
      if (|bus.req_ready) begin
        granted  = 1'b1;
        r.rdy    = bus.req_ready;
        r.busy_g = bus.mul_busy;
      end else begin
        if (bus.rsp_valid) r.early_rsp = 1'b1;
        @(negedge clk);
        #1;
      end
    end
    if (!granted) begin
      bus.req_valid[id] = 1'b0;
      checkOutput("grant_wait_expired", 0, 1);
      return;
    end
    for (int n = 1; n < 300 && r.lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) bus.req_valid[id] = 1'b0;
      #1;
      if (bus.mul_start) r.starts++;
      if (|bus.req_ready) r.extra_rdy++;
      if (bus.rsp_valid) begin
        r.lat  = n;
        r.rid  = int'(bus.rsp_id);
        r.rab  = int'($signed(bus.rsp_ab));
        r.terr = bus.timeout_err;
      end
    end
    if (r.lat < 0) begin
      checkOutput("rsp_wait_expired", 0, 1);
      return;
    end
    @(negedge clk);
    #1;
    r.rab_after = int'($signed(bus.rsp_ab));
    r.rv_after  = bus.rsp_valid;
  endtask

  int   g_ids[8];
  int   r_ids[8];
  int   r_abs[8];
  int   g_cnt;
  int   r_cnt;
  logic two_hot;

  // Several requesters at once; non-held requesters drop valid after their grant.
  task automatic runMulti(input logic [3:0] vmask, input logic [3:0] hold,
                          input logic [31:0] a_all, input logic [31:0] b_all, input int nresp);
    int drop;
    g_cnt = 0;
    r_cnt = 0;
    two_hot = 1'b0;
    drop = -1;
    @(negedge clk);
    bus.req_a     = a_all;
    bus.req_b     = b_all;
    bus.req_valid = vmask;
    for (int c = 0; c < 400 && r_cnt < nresp; c++) begin
      #1;
      if ($countones(bus.req_ready) > 1) two_hot = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ready[i] && g_cnt < 8) begin
          g_ids[g_cnt] = i;
          g_cnt++;
          if (!hold[i]) drop = i;
        end
      end
      if (bus.rsp_valid && r_cnt < 8) begin
        r_ids[r_cnt] = int'(bus.rsp_id);
        r_abs[r_cnt] = int'($signed(bus.rsp_ab));
        r_cnt++;
      end
      if (r_cnt < nresp) begin
        @(negedge clk);
        if (drop >= 0) begin
          bus.req_valid[drop] = 1'b0;
          drop = -1;
        end
      end
    end
    bus.req_valid = '0;
    checkOutput("multi_rsp_count", r_cnt, nresp);
  endtask

  vec_t vecs[5];
  res_t r;
  int   exp_ids[4];
  int   exp_abs[4];

  initial begin
    vecs[0] = '{id: 0, a: -5,   b: -17,  k: 8, exp_ab: 85};
    vecs[1] = '{id: 1, a: -128, b: -128, k: 3, exp_ab: 16384};
    vecs[2] = '{id: 2, a: -128, b: 127,  k: 1, exp_ab: -16256};
    vecs[3] = '{id: 3, a: 0,    b: -1,   k: 5, exp_ab: 0};
    vecs[4] = '{id: 0, a: 127,  b: 127,  k: 2, exp_ab: 16129};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_idle",        int'(bus.idle),        1);
    checkOutput("reset_mul_start",   int'(bus.mul_start),   0);
    checkOutput("reset_rsp_valid",   int'(bus.rsp_valid),   0);
    checkOutput("reset_rsp_id",      int'(bus.rsp_id),      0);
    checkOutput("reset_rsp_ab",      int'(bus.rsp_ab),      0);
    checkOutput("reset_timeout_err", int'(bus.timeout_err), 0);
    checkOutput("reset_mul_a",       int'(bus.mul_a),       0);
    checkOutput("reset_mul_b",       int'(bus.mul_b),       0);
    checkOutput("reset_req_ready",   int'(bus.req_ready),   0);

    exp_ids = '{0, 1, 2, 3};
    exp_abs = '{6, 20, -42, -72};
    for (int round = 0; round < 2; round++) begin
      mdl_k = 3;
      runMulti(4'b1111, 4'b0000, {8'd8, 8'hFA, 8'd4, 8'd2}, {8'hF7, 8'd7, 8'd5, 8'd3}, 4);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("all4_r%0d_grant%0d", round, i), g_ids[i], exp_ids[i]);
        checkOutput($sformatf("all4_r%0d_rsp_id%0d", round, i), r_ids[i], exp_ids[i]);
        checkOutput($sformatf("all4_r%0d_rsp_ab%0d", round, i), r_abs[i], exp_abs[i]);
      end
      checkOutput($sformatf("all4_r%0d_two_hot", round), int'(two_hot), 0);
    end

    foreach (vecs[v]) begin
      applyStimulus(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].k, r);
      checkOutput($sformatf("vec%0d_ready", v),     int'(r.rdy), 1 << vecs[v].id);
      checkOutput($sformatf("vec%0d_starts", v),    r.starts, 1);
      checkOutput($sformatf("vec%0d_latency", v),   r.lat, 3 + vecs[v].k);
      checkOutput($sformatf("vec%0d_rsp_id", v),    r.rid, vecs[v].id);
      checkOutput($sformatf("vec%0d_rsp_ab", v),    r.rab, vecs[v].exp_ab);
      checkOutput($sformatf("vec%0d_ab_held", v),   r.rab_after, vecs[v].exp_ab);
      checkOutput($sformatf("vec%0d_rv_single", v), int'(r.rv_after), 0);
      checkOutput($sformatf("vec%0d_extra_rdy", v), r.extra_rdy, 0);
    end

    mdl_k = 2;
    runMulti(4'b1010, 4'b1010, {8'hFE, 8'd0, 8'd3, 8'd0}, {8'd5, 8'd0, 8'd4, 8'd0}, 4);
    exp_ids = '{1, 3, 1, 3};
    exp_abs = '{12, -10, 12, -10};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fair_grant%0d", i), g_ids[i], exp_ids[i]);
      checkOutput($sformatf("fair_rsp_id%0d", i), r_ids[i], exp_ids[i]);
      checkOutput($sformatf("fair_rsp_ab%0d", i), r_abs[i], exp_abs[i]);
    end
    checkOutput("fair_two_hot", int'(two_hot), 0);

    mdl_stall = 1'b1;
    applyStimulus(2, 10, 10, 4, r);
    mdl_stall = 1'b0;
    checkOutput("tmo_latency", r.lat, TIMEOUT + 2);
    checkOutput("tmo_starts",  r.starts, 1);
    checkOutput("tmo_rsp_id",  r.rid, 2);
    checkOutput("tmo_rsp_ab",  r.rab, 0);
    checkOutput("tmo_err",     int'(r.terr), 1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("tmo_err_sticky", int'(bus.timeout_err), 1);
    applyStimulus(0, 7, -3, 4, r);
    checkOutput("post_tmo_latency", r.lat, 7);
    checkOutput("post_tmo_rsp_ab",  r.rab, -21);
    checkOutput("post_tmo_err",     int'(r.terr), 1);

    // Reset while the multiplier is mid-operation, then serve req2 once busy drops.
    mdl_k = 20;
    @(negedge clk);
    bus.req_a[15:8] = 8'd2;
    bus.req_b[15:8] = 8'd2;
    bus.req_valid   = 4'b0010;
    #1;
    checkOutput("rir_ready", int'(bus.req_ready), 2);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rir_busy_before_reset", int'(bus.mul_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_a[23:16] = 8'hFD;
    bus.req_b[23:16] = 8'hFD;
    bus.req_valid    = 4'b0100;
    #1;
    checkOutput("rir_idle",        int'(bus.idle),        1);
    checkOutput("rir_rsp_valid",   int'(bus.rsp_valid),   0);
    checkOutput("rir_mul_start",   int'(bus.mul_start),   0);
    checkOutput("rir_mul_a",       int'(bus.mul_a),       0);
    checkOutput("rir_mul_b",       int'(bus.mul_b),       0);
    checkOutput("rir_rsp_id",      int'(bus.rsp_id),      0);
    checkOutput("rir_rsp_ab",      int'(bus.rsp_ab),      0);
    checkOutput("rir_timeout_err", int'(bus.timeout_err), 0);
    checkOutput("rir_no_grant",    int'(bus.req_ready),   0);
    applyStimulus(2, -3, -3, 2, r);
    checkOutput("rir_ready2",    int'(r.rdy), 4);
    checkOutput("rir_busy_g",    int'(r.busy_g), 0);
    checkOutput("rir_early_rsp", int'(r.early_rsp), 0);
    checkOutput("rir_latency",   r.lat, 5);
    checkOutput("rir_rsp_id2",   r.rid, 2);
    checkOutput("rir_rsp_ab2",   r.rab, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one sequential signed multiplier (start/busy handshake, 8x8 -> 16) among NREQ requesters. In the spiking-NN datapath it sits between the neuron weight-accumulation units and the single multiplier instance. It accepts one operand pair at a time, drives the multiplier start pulse, tracks busy, and returns the product tagged with the requester id. A timeout guard prevents a lock-up if the multiplier stalls.

## Interface

- NREQ, 4, number of requesters (2..8)
- IDW, 2, id width, equal to clog2(NREQ)
- TIMEOUT, 64, maximum cycles spent in ARM+RUN before abort (>= 4)

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request i holds operands valid
- req_a  in  NREQ*8  signed operand a; requester i at [8i+7:8i]
- req_b  in  NREQ*8  signed operand b; same packing
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- rsp_valid  out  1  one-cycle result pulse
- rsp_id  out  IDW  requester index of the result
- rsp_ab  out  16  signed product
- timeout_err  out  1  sticky abort flag, cleared only by rst
- idle  out  1  high in IDLE
- mul_a  out  8  multiplier operand a (registered)
- mul_b  out  8  multiplier operand b (registered)
- mul_start  out  1  multiplier start, exactly one cycle per operation
- mul_busy  in  1  multiplier busy
- mul_ab  in  16  multiplier product, valid on the first cycle busy is low after being high

## Operation

- States: IDLE, LAUNCH, ARM, RUN, RESP.
- IDLE: grants when any req_valid is high and mul_busy=0.
  - The winner is the first set bit searching upward from ptr, wrapping at NREQ.
  - req_ready[g] is combinational (IDLE & valid & winner) and at most one bit is high.
  - On transfer: register mul_a/mul_b from requester g, latch id=g, set ptr=(g+1) mod NREQ, go to LAUNCH.
- LAUNCH: mul_start=1, clear the timeout counter, go to ARM.
- ARM: if mul_busy=1, go to RUN; otherwise increment the counter.
- RUN: if mul_busy=0, capture mul_ab into rsp_ab and go to RESP; otherwise increment the counter.
- Timeout: if the counter reaches TIMEOUT-1 in ARM or RUN without exiting, set timeout_err=1, set rsp_ab=0, and go to RESP. A response is still issued so the requester never hangs.
- RESP: rsp_valid=1 with rsp_id=id, then go to IDLE.
- req_ready is 0 in every state other than IDLE.
- Requesters must hold req_valid and operands stable until granted. Deasserting before the grant is allowed; that request is then simply not served.
- Arithmetic: operands are two's complement 8-bit. The product is passed through unmodified from mul_ab; this block does no arithmetic.
- Reset values: state=IDLE, ptr=0, mul_a=0, mul_b=0, mul_start=0, rsp_valid=0, rsp_id=0, rsp_ab=0, timeout_err=0, counter=0, idle=1.
- Reset mid-operation: the in-flight op is dropped and no rsp_valid is issued. The next grant waits for mul_busy=0.

## Timing

- Cycle 0 (IDLE): grant.
- Cycle 1: mul_start=1.
- Cycle 2 onward: ARM. If the multiplier busy rises at cycle 2 and stays high for K cycles (first low at cycle 2+K), capture happens at 2+K.
- rsp_valid is at cycle 3+K, and the next grant is possible at cycle 4+K.
- Minimum turnaround is 4+K cycles per operation.
- rsp_ab and rsp_id hold their values after RESP until the next RESP.
- Simultaneous rst and any event: rst wins.

## Test plan

- Single request: req0 with a=-5, b=-17 (multiplier model K=8) -> one req_ready[0] pulse, one mul_start cycle, then rsp_valid at cycle 11 with rsp_ab=85, rsp_id=0.
- All four requests valid from reset, with products 2*3, 4*5, -6*7, 8*-9 -> responses in id order 0,1,2,3 with 6, 20, -42, -72. A second round with all four requests again starts at id 0.
- Fairness: req1 and req3 held high continuously -> grants alternate 1,3,1,3 and req_ready is never two-hot.
- Boundary operands: -128*-128 -> 16384; -128*127 -> -16256; 0*-1 -> 0; 127*127 -> 16129.
- Timeout: multiplier model never raises busy, TIMEOUT=64 -> rsp_valid with rsp_ab=0 and timeout_err=1, which stays set. A following normal request completes correctly with timeout_err still 1.
- Reset in RUN: rst asserted for one cycle -> next cycle has all outputs at reset values and no rsp_valid. With mul_busy still high and req2 valid, no grant until mul_busy=0, then req2 is served.
